freq_filter_stream: RTL and testbench
=====================================

// Module: freq_filter_stream
// PURPOSE
//  Streaming frequency-domain filter. Multiplies each complex FFT bin by a per-bin complex
//  coefficient, then rounds and saturates the result. Replaces the fixed 32-point stand-alone
//  filter: sample width, FFT length and coefficient format are parameters. Coefficients sit
//  in a double-buffered, run-time-loadable RAM. The bin index wraps every frame, and a bypass
//  mode is provided. Sits between the FFT output stage and the IFFT input.
// PARAMETERS
//  DW     16  data width of in_r/in_i/out_r/out_i (signed)
//  CW     16  coefficient width (signed)
//  LOG2N   5  log2 of FFT length; N = 2**LOG2N bins per frame
//  FRAC   15  coefficient fractional bits (Q1.15 by default); must satisfy 1 <= FRAC < CW
// PORTS
//  clk          in   1      clock; all logic on posedge
//  reset_n      in   1      reset, asynchronous, active-low
//  in_valid     in   1      input bin valid
//  in_sop       in   1      first bin of a frame; qualified by in_valid
//  in_r, in_i   in   DW     input bin, signed
//  bypass       in   1      pass data through unscaled; sampled at each frame start
//  coef_we      in   1      write strobe to the shadow coefficient bank
//  coef_addr    in   LOG2N  bin index for the write
//  coef_r,coef_i in  CW     coefficient, signed
//  coef_swap    in   1      one-cycle pulse: shadow bank becomes active at the next frame start
//  out_valid    out  1      output bin valid
//  out_sop      out  1      first output bin of a frame
//  out_last     out  1      output bin index N-1
//  out_r, out_i out  DW     filtered bin, signed
//  out_sat      out  1      this output bin saturated (real or imaginary part)
//  swap_pend    out  1      swap requested, not yet applied
// BEHAVIOUR
//  - Reset (async assert, sync deassert handled externally): all outputs 0, bin counter 0,
//    active bank 0, swap_pend 0, bypass latch 0. Coefficient RAM contents are not reset.
//  - Bin counter advances on each in_valid and wraps N-1 -> 0. No saturation at N-1.
//    in_sop with in_valid forces the counter to 0 for that bin (frame resync).
//  - Frame start is either in_valid&&in_sop or in_valid at counter 0. At frame start:
//    - the bypass latch loads bypass;
//    - if swap_pend=1, the active bank toggles and swap_pend clears. The new bank applies
//      to this bin.
//  - coef_swap sets swap_pend. If coef_swap coincides with a frame start, the swap applies
//    at the following frame.
//  - Writes always target the inactive bank, so a write never disturbs the current frame.
//    A write in the same cycle as the bank toggle goes to the bank that is inactive after
//    the toggle.
//  - Pipeline: fixed latency 3 cycles from in_valid to out_valid. No backpressure.
//    Gaps in in_valid pass through as gaps. Pipeline stages:
//    - S1: coefficient RAM read (synchronous); data, valid, sop, last and bypass delayed
//      to match.
//    - S2: four signed products, each DW+CW bits. Then re = ar*br - ai*bi and
//      im = ar*bi + ai*br, each DW+CW+1 bits.
//    - S3: add 2**(FRAC-1) (round half up), arithmetic shift right by FRAC, then saturate
//      to [-2**(DW-1), 2**(DW-1)-1]. out_sat = saturation of re OR saturation of im.
//  - Bypass: out = in, delayed 3 cycles; out_sat = 0.
//  - out_sop and out_last derive from the S1 bin index. They are only asserted together
//    with out_valid.
//  - If reset_n is asserted mid-frame, the pipeline empties immediately, with no partial
//    outputs after release. The next in_valid is bin 0 unless in_sop says otherwise.
// STRUCTURE
//  - Package freq_filter_pkg:
//    - typedef cplx_t {logic signed [DW-1:0] r, i};
//    - localparam PIPE_LAT = 3;
//    - function sat_round() shared with the bench model.
//  - Sub-module cmul_round_sat: stages S2-S3, parametrised by DW/CW/FRAC, with valid
//    pass-through. Top level: counter, bank control, 2 x N x 2CW RAM, S1 alignment.
// TESTING
//  1. Identity. Load all coef = (2**15, 0) via the default 32767 path, i.e. coef = (32767, 0).
//     Stream one frame with in = (1000, -2000). Expect out = (1000, -2000) after 3 cycles,
//     with out_sop on bin 0 and out_last on bin 31.
//  2. Complex rotate. Load coef = (0, 32767) on bin 5, swap, and stream (16384, 0) at bin 5.
//     Expect out = (0, 16384) on that bin.
//  3. Saturation. in = (-32768, -32768), coef = (-32768, -32768): re = 0, im = 2**31 >> 15.
//     Expect out = (0, 32767) with out_sat = 1.
//  4. Bank swap. Pulse coef_swap mid-frame together with writes. Expect the current frame to
//     use the old coefficients, the next frame to use the new ones, and swap_pend 1 -> 0 at
//     the frame start.
//  5. Wrap and gaps. Stream 2.5 frames with random in_valid gaps and no in_sop. Expect the
//     bin index to wrap 31 -> 0 and out_last every 32 valid outputs. Then assert in_sop at
//     bin 7 and expect out_sop on the next output.
//  6. Reset and bypass. Assert reset_n low for 1 cycle mid-frame: all outputs drop to 0 and
//     no stale outputs follow. Set bypass = 1 at a frame start: out equals in exactly, with
//     out_sat = 0.

Source files
------------

// File: rtl/freq_filter_pkg.sv
// Shared types and the round/saturate helper for the streaming frequency-domain filter.
package freq_filter_pkg;

  localparam int CPLX_DW  = 16;
  localparam int PIPE_LAT = 3;
  localparam int SAT_W    = 64;

  typedef struct packed {
    logic signed [CPLX_DW-1:0] r;
    logic signed [CPLX_DW-1:0] i;
  } cplx_t;

  typedef struct packed {
    logic signed [SAT_W-1:0] val;
    logic                    sat;
  } sat_res_t;

  // Round half up, drop frac bits, then clamp to a dw-bit signed range.
  function automatic sat_res_t sat_round(input logic signed [SAT_W-1:0] v,
                                         input int dw, input int frac);
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] t;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sat_res_t res;
    one = 64'sd1;
    t   = (v + (one <<< (frac - 1))) >>> frac;
    hi  = (one <<< (dw - 1)) - one;
    lo  = -(one <<< (dw - 1));
    res.val = t;
    res.sat = 1'b0;
    if (t > hi) begin
      res.val = hi;
      res.sat = 1'b1;
    end else if (t < lo) begin
      res.val = lo;
      res.sat = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/freq_filter_stream_cmul.sv
// Stages S2-S3: complex multiply, then round/saturate, with valid/sop/last/bypass carried along.
module cmul_round_sat
  import freq_filter_pkg::*;
#(
  parameter int DW   = 16,
  parameter int CW   = 16,
  parameter int FRAC = 15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  input  logic                 in_sop,
  input  logic                 in_last,
  input  logic                 in_bypass,
  input  logic signed [DW-1:0] a_r,
  input  logic signed [DW-1:0] a_i,
  input  logic signed [CW-1:0] b_r,
  input  logic signed [CW-1:0] b_i,
  output logic                 out_valid,
  output logic                 out_sop,
  output logic                 out_last,
  output logic signed [DW-1:0] out_r,
  output logic signed [DW-1:0] out_i,
  output logic                 out_sat
);

  localparam int PW = DW + CW;
  localparam int SW = PW + 1;

  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [SW-1:0] re_next, im_next;
  logic signed [SW-1:0] re2_reg, im2_reg;
  logic signed [DW-1:0] ar2_reg, ai2_reg;
  logic                 v2_reg, sop2_reg, last2_reg, byp2_reg;
  sat_res_t             re_res, im_res;

  always_comb begin
    p_rr    = a_r * b_r;
    p_ii    = a_i * b_i;
    p_ri    = a_r * b_i;
    p_ir    = a_i * b_r;
    re_next = SW'(p_rr) - SW'(p_ii);
    im_next = SW'(p_ri) + SW'(p_ir);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v2_reg    <= 1'b0;
      sop2_reg  <= 1'b0;
      last2_reg <= 1'b0;
      byp2_reg  <= 1'b0;
      re2_reg   <= '0;
      im2_reg   <= '0;
      ar2_reg   <= '0;
      ai2_reg   <= '0;
    end else begin
      v2_reg    <= in_valid;
      sop2_reg  <= in_valid && in_sop;
      last2_reg <= in_valid && in_last;
      byp2_reg  <= in_bypass;
      re2_reg   <= re_next;
      im2_reg   <= im_next;
      ar2_reg   <= a_r;
      ai2_reg   <= a_i;
    end
  end

  always_comb begin
    re_res = sat_round(SAT_W'(re2_reg), DW, FRAC);
    im_res = sat_round(SAT_W'(im2_reg), DW, FRAC);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_last  <= 1'b0;
      out_r     <= '0;
      out_i     <= '0;
      out_sat   <= 1'b0;
    end else begin
      out_valid <= v2_reg;
      out_sop   <= sop2_reg;
      out_last  <= last2_reg;
      out_r     <= byp2_reg ? ar2_reg : re_res.val[DW-1:0];
      out_i     <= byp2_reg ? ai2_reg : im_res.val[DW-1:0];
      out_sat   <= v2_reg && !byp2_reg && (re_res.sat || im_res.sat);
    end
  end

endmodule

// File: rtl/freq_filter_stream.sv
// Streaming per-bin complex filter: bin counter, double-buffered coefficient RAM, S1 alignment.
module freq_filter_stream
  import freq_filter_pkg::*;
#(
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int LOG2N = 5,
  parameter int FRAC  = 15
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  input  logic                    in_sop,
  input  logic signed [DW-1:0]    in_r,
  input  logic signed [DW-1:0]    in_i,
  input  logic                    bypass,
  input  logic                    coef_we,
  input  logic [LOG2N-1:0]        coef_addr,
  input  logic signed [CW-1:0]    coef_r,
  input  logic signed [CW-1:0]    coef_i,
  input  logic                    coef_swap,
  output logic                    out_valid,
  output logic                    out_sop,
  output logic                    out_last,
  output logic signed [DW-1:0]    out_r,
  output logic signed [DW-1:0]    out_i,
  output logic                    out_sat,
  output logic                    swap_pend
);

  localparam int N = 2 ** LOG2N;

  logic [LOG2N-1:0] bin_cnt_reg, cur_bin, bin1_reg;
  logic             frame_start, bank_eff, bypass_eff;
  logic             active_bank_reg, swap_pend_reg, bypass_reg;
  logic             v1_reg, byp1_reg;
  logic signed [DW-1:0] d1_r_reg, d1_i_reg;

  logic [2*CW-1:0]  coef_mem [2*N];
  logic [2*CW-1:0]  coef_rd_reg;

  // The toggle takes effect on the frame-start bin itself, so the read bank is combinational.
  always_comb begin
    cur_bin     = (in_valid && in_sop) ? '0 : bin_cnt_reg;
    frame_start = in_valid && (in_sop || bin_cnt_reg == '0);
    bank_eff    = active_bank_reg ^ (frame_start && swap_pend_reg);
    bypass_eff  = frame_start ? bypass : bypass_reg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bin_cnt_reg     <= '0;
      active_bank_reg <= 1'b0;
      swap_pend_reg   <= 1'b0;
      bypass_reg      <= 1'b0;
    end else begin
      if (in_valid) bin_cnt_reg <= cur_bin + 1'b1;
      active_bank_reg <= bank_eff;
      bypass_reg      <= bypass_eff;
      swap_pend_reg   <= coef_swap || (swap_pend_reg && !frame_start);
    end
  end

  // Writes always land in the bank that is inactive after any same-cycle toggle.
  always_ff @(posedge clk) begin
    if (coef_we) coef_mem[{~bank_eff, coef_addr}] <= {coef_r, coef_i};
    coef_rd_reg <= coef_mem[{bank_eff, cur_bin}];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_reg   <= 1'b0;
      bin1_reg <= '0;
      byp1_reg <= 1'b0;
      d1_r_reg <= '0;
      d1_i_reg <= '0;
    end else begin
      v1_reg   <= in_valid;
      bin1_reg <= cur_bin;
      byp1_reg <= bypass_eff;
      d1_r_reg <= in_r;
      d1_i_reg <= in_i;
    end
  end

  cmul_round_sat #(
    .DW   (DW),
    .CW   (CW),
    .FRAC (FRAC)
  ) u_cmul (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (v1_reg),
    .in_sop    (bin1_reg == '0),
    .in_last   (bin1_reg == LOG2N'(N - 1)),
    .in_bypass (byp1_reg),
    .a_r       (d1_r_reg),
    .a_i       (d1_i_reg),
    .b_r       ($signed(coef_rd_reg[2*CW-1:CW])),
    .b_i       ($signed(coef_rd_reg[CW-1:0])),
    .out_valid (out_valid),
    .out_sop   (out_sop),
    .out_last  (out_last),
    .out_r     (out_r),
    .out_i     (out_i),
    .out_sat   (out_sat)
  );

  assign swap_pend = swap_pend_reg;

endmodule

// File: tb/tb_freq_filter_stream.sv
// Scoreboard bench: a frame-level reference model queues expected bins, a monitor checks outputs.
module tb_freq_filter_stream;
  import freq_filter_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0, in_sop = 1'b0, bypass = 1'b0, coef_we = 1'b0, coef_swap = 1'b0;
  logic signed [15:0] in_r = '0, in_i = '0, coef_r = '0, coef_i = '0;
  logic [4:0] coef_addr = '0;
  logic out_valid, out_sop, out_last, out_sat, swap_pend;
  logic signed [15:0] out_r, out_i;

  int checks = 0;
  int errors = 0;

  typedef struct {
    cplx_t d;
    bit    sat;
    bit    sop;
    bit    last;
  } exp_t;

  exp_t q[$];

  // Reference model state: frame position, banks, pending swap, bypass latch.
  int m_bin = 0;
  bit m_act = 0, m_pend = 0, m_byp = 0;
  int mr[2][32];
  int mi[2][32];

  freq_filter_stream #(.DW(16), .CW(16), .LOG2N(5), .FRAC(15)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_sop(in_sop),
    .in_r(in_r), .in_i(in_i), .bypass(bypass), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_r(coef_r), .coef_i(coef_i), .coef_swap(coef_swap),
    .out_valid(out_valid), .out_sop(out_sop), .out_last(out_last),
    .out_r(out_r), .out_i(out_i), .out_sat(out_sat), .swap_pend(swap_pend)
  );

  always #5 clk = ~clk;

  function automatic int scale(input longint x, output bit s);
    longint y;
    y = (x + 16384) >>> 15;
    s = 1'b0;
    if (y > 32767) begin y = 32767; s = 1'b1; end
    if (y < -32768) begin y = -32768; s = 1'b1; end
    return int'(y);
  endfunction

  function automatic exp_t expect_bin(input int ar, input int ai, input int br, input int bi,
                                      input bit byp, input int b);
    exp_t e;
    bit s1, s2;
    int yr, yi;
    e.sop  = (b == 0);
    e.last = (b == 31);
    if (byp) begin
      e.d.r = ar[15:0];
      e.d.i = ai[15:0];
      e.sat = 1'b0;
    end else begin
      yr = scale(longint'(ar) * br - longint'(ai) * bi, s1);
      yi = scale(longint'(ar) * bi + longint'(ai) * br, s2);
      e.d.r = yr[15:0];
      e.d.i = yi[15:0];
      e.sat = s1 | s2;
    end
    return e;
  endfunction

  task automatic drive(input bit v, input bit sop, input int r, input int i, input bit byp,
                       input bit we, input int addr, input int cr, input int ci, input bit swap);
    bit fs;
    int b;
    in_valid = v; in_sop = sop; in_r = r[15:0]; in_i = i[15:0]; bypass = byp;
    coef_we = we; coef_addr = addr[4:0]; coef_r = cr[15:0]; coef_i = ci[15:0]; coef_swap = swap;
    fs = v && (sop || m_bin == 0);
    b  = (v && sop) ? 0 : m_bin;
    if (fs) begin
      m_byp = byp;
      if (m_pend) begin m_act = !m_act; m_pend = 1'b0; end
    end
    if (swap) m_pend = 1'b1;
    if (we) begin mr[!m_act][addr] = cr; mi[!m_act][addr] = ci; end
    if (v) begin
      q.push_back(expect_bin(r, i, mr[m_act][b], mi[m_act][b], m_byp, b));
      m_bin = (b + 1) % 32;
    end
    @(posedge clk);
    #1;
    checks++;
    if (swap_pend !== m_pend) begin
      errors++;
      $display("FAIL swap_pend: got %0b required %0b", swap_pend, m_pend);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic write_coef(input int addr, input int cr, input int ci, input bit swap);
    drive(0, 0, 0, 0, 0, 1, addr, cr, ci, swap);
  endtask

  function automatic int rnd16();
    int sel;
    sel = int'($urandom_range(0, 7));
    if (sel == 0) return -32768;
    if (sel == 1) return 32767;
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  // Streams nbins valid bins; optional gaps, random data, random shadow writes and a swap pulse.
  task automatic run_bins(input int nbins, input int fr, input int fi, input bit rnd,
                          input bit byp, input bit gaps, input bit wr, input int swap_at,
                          input bit first_sop);
    int k;
    bit v;
    int r, i;
    k = 0;
    while (k < nbins) begin
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      r = rnd ? rnd16() : fr;
      i = rnd ? rnd16() : fi;
      drive(v, v && first_sop && (k == 0), r, i, byp, wr && ($urandom_range(0, 1) == 1),
            int'($urandom_range(0, 31)), rnd16(), rnd16(), v && (k == swap_at));
      if (v) k++;
    end
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    in_valid = 0; in_sop = 0; coef_we = 0; coef_swap = 0; bypass = 0;
    q.delete();
    m_bin = 0; m_act = 0; m_pend = 0; m_byp = 0;
    #1;
    checks++;
    if (out_valid !== 0 || out_sop !== 0 || out_last !== 0 || out_r !== 0 || out_i !== 0 ||
        out_sat !== 0 || swap_pend !== 0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0b sop=%0b last=%0b r=%0d i=%0d sat=%0b pend=%0b required all 0",
               out_valid, out_sop, out_last, out_r, out_i, out_sat, swap_pend);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      checks++;
      if (out_valid) begin
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got r=%0d i=%0d with no bin outstanding", out_r, out_i);
        end else begin
          exp_t e;
          e = q.pop_front();
          $display("out r=%0d i=%0d sat=%0b sop=%0b last=%0b", out_r, out_i, out_sat, out_sop, out_last);
          if (out_r !== e.d.r || out_i !== e.d.i || out_sat !== e.sat ||
              out_sop !== e.sop || out_last !== e.last) begin
            errors++;
            $display("FAIL bin_output: got r=%0d i=%0d sat=%0b sop=%0b last=%0b required r=%0d i=%0d sat=%0b sop=%0b last=%0b",
                     out_r, out_i, out_sat, out_sop, out_last, e.d.r, e.d.i, e.sat, e.sop, e.last);
          end
        end
      end else if (out_sop || out_last) begin
        errors++;
        $display("FAIL flags_without_valid: got sop=%0b last=%0b required 0", out_sop, out_last);
      end
    end
  end

  initial begin
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 32; a++) begin mr[b][a] = 0; mi[b][a] = 0; end

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 0 || out_r !== 0 || out_i !== 0 || out_sat !== 0 || swap_pend !== 0) begin
      errors++;
      $display("FAIL initial_reset: got v=%0b r=%0d i=%0d sat=%0b pend=%0b required all 0",
               out_valid, out_r, out_i, out_sat, swap_pend);
    end
    reset_n = 1'b1;
    idle(2);

    // 1. Identity coefficients, one frame of (1000, -2000)
    for (int a = 0; a < 32; a++) write_coef(a, 32767, 0, a == 31);
    run_bins(32, 1000, -2000, 0, 0, 0, 0, -1, 1);
    idle(4);

    // 2. Rotate by j on bin 5
    for (int a = 0; a < 32; a++) write_coef(a, (a == 5) ? 0 : 32767, (a == 5) ? 32767 : 0, a == 31);
    run_bins(32, 16384, 0, 0, 0, 0, 0, -1, 1);
    idle(4);

    // 3. Saturation on bin 9
    write_coef(9, -32768, -32768, 1);
    run_bins(32, -32768, -32768, 0, 0, 0, 0, -1, 1);
    idle(4);

    // 4. Swap mid-frame with concurrent writes, then a frame on the new bank
    run_bins(32, 0, 0, 1, 0, 0, 1, 10, 1);
    run_bins(32, 0, 0, 1, 0, 0, 0, -1, 1);
    idle(4);

    // 5. Wrap with gaps and no sop, then resync at bin 7
    run_bins(80, 0, 0, 1, 0, 1, 0, -1, 0);
    while (m_bin != 7) drive(1, 0, rnd16(), rnd16(), 0, 0, 0, 0, 0, 0);
    drive(1, 1, rnd16(), rnd16(), 0, 0, 0, 0, 0, 0);
    run_bins(5, 0, 0, 1, 0, 0, 0, -1, 0);
    idle(4);

    // 6. Reset mid-frame, then a bypass frame
    run_bins(10, 0, 0, 1, 0, 0, 0, -1, 1);
    pulse_reset();
    idle(5);
    run_bins(32, 0, 0, 1, 1, 0, 0, -1, 0);
    idle(4);

    // Random frames: gaps, writes, swaps and bypass changes
    for (int f = 0; f < 4; f++)
      run_bins(32, 0, 0, 1, $urandom_range(0, 1) == 1, 1, 1, int'($urandom_range(0, 31)), 1);
    idle(PIPE_LAT + 3);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d bins never output required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
